// File: rtl/seg7_scanner.sv
// Eight-digit time-multiplexed seven-segment scanner with per-frame snapshot,
// per-digit mask/decimal point and optional leading-zero blanking.
module seg7_scanner #(
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rotate,
   input  logic        en,
   input  logic [31:0] data_in,
   input  logic [7:0]  dp_in,
   input  logic [7:0]  mask_in,
   input  logic        blz,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame
);

   localparam int unsigned NDIG = 8;
   localparam int unsigned DW   = 32;
   localparam int unsigned SW   = 7;
   localparam int unsigned PW   = NDIG + SW + 1;

   localparam logic [PW-1:0] DARK = {8'hFF, 7'h7F, 1'b1};

   typedef enum logic {IDLE, SCAN} state_t;

   state_t          state;
   logic [2:0]      idx;
   logic [DW-1:0]   data_snap;
   logic [NDIG-1:0] dp_snap;
   logic [NDIG-1:0] mask_snap;
   logic            blz_snap;

   function automatic logic [SW-1:0] hex7(input logic [3:0] n);
      logic [SW-1:0] s;
      case (n)
         4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
         4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
         4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
         4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Pin pattern {an, seg, dp} for digit k of a given frame snapshot.
   function automatic logic [PW-1:0] drive(input logic [2:0]      k,
                                           input logic [DW-1:0]   d,
                                           input logic [NDIG-1:0] dpv,
                                           input logic [NDIG-1:0] mask,
                                           input logic            b);
      logic lz;
      lz = BLANK_LZ && b && (k != 3'd0);
      for (int j = 0; j < int'(NDIG); j++) begin
         if (j >= int'(k) && d[4*j +: 4] != 4'h0) lz = 1'b0;
      end
      if (mask[k] || lz) return DARK;
      return {~(8'b1 << k), hex7(d[{k, 2'b00} +: 4]), ~dpv[k]};
   endfunction

   // Scan FSM: en overrides rotate; snapshot reloads at frame start only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         idx       <= 3'd0;
         data_snap <= '0;
         dp_snap   <= '0;
         mask_snap <= '0;
         blz_snap  <= 1'b0;
         {an, seg, dp} <= DARK;
         frame     <= 1'b0;
      end else begin
         frame <= 1'b0;
         if (!en) begin
            state <= IDLE;
            idx   <= 3'd0;
            {an, seg, dp} <= DARK;
         end else if (rotate) begin
            if (state == IDLE || idx == 3'd7) begin
               state     <= SCAN;
               idx       <= 3'd0;
               data_snap <= data_in;
               dp_snap   <= dp_in;
               mask_snap <= mask_in;
               blz_snap  <= blz;
               frame     <= 1'b1;
               {an, seg, dp} <= drive(3'd0, data_in, dp_in, mask_in, blz);
            end else begin
               idx <= 3'(idx + 3'd1);
               {an, seg, dp} <= drive(3'(idx + 3'd1), data_snap, dp_snap, mask_snap, blz_snap);
            end
         end
      end
   end

endmodule
